// File: rtl/accel_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : accel_issue_seq
// Description : Accepts one decoded vector op at a time and issues it to the
//               PE array as ceil(vl/NUM_PE) beats with per-lane enables.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_issue_seq #(
    parameter int NUM_PE = 4,
    parameter int VL_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [3:0]        arith_op_i,
    input  logic [1:0]        operand_sel_i,
    input  logic [1:0]        out_mode_i,
    input  logic [1:0]        sat_mode_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic [31:0]       scalar_i,
    output logic              pe_valid_o,
    input  logic              pe_ready_i,
    output logic [3:0]        pe_arith_op_o,
    output logic [1:0]        pe_operand_sel_o,
    output logic [1:0]        pe_out_mode_o,
    output logic [1:0]        pe_sat_mode_o,
    output logic [31:0]       pe_scalar_o,
    output logic [VL_W-1:0]   pe_elem_base_o,
    output logic [NUM_PE-1:0] pe_lane_en_o,
    output logic              pe_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              illegal_o
);

    localparam int            BW   = VL_W + 1;
    localparam logic [VL_W:0] STEP = BW'(NUM_PE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      arith_q, arith_d;
    logic [1:0]      opsel_q, opsel_d;
    logic [1:0]      outm_q, outm_d;
    logic [1:0]      satm_q, satm_d;
    logic [31:0]     scalar_q, scalar_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W:0]   base_q, base_d;
    logic            illegal_q, illegal_d;

    logic            w_accept;
    logic            w_op_illegal;
    logic            w_issuing;
    logic [VL_W:0]   w_vl_ext;
    logic [VL_W:0]   w_base_next;
    logic            w_last;

    assign w_accept     = instr_valid_i && (state_q == ST_IDLE);
    assign w_op_illegal = (arith_op_i > 4'd9) || (out_mode_i == 2'd3) || (sat_mode_i == 2'd3);
    assign w_issuing    = (state_q == ST_ISSUE);
    // One extra bit keeps base+NUM_PE from wrapping when vl is near 2^VL_W.
    assign w_vl_ext     = {1'b0, vl_q};
    assign w_base_next  = base_q + STEP;
    assign w_last       = (w_base_next >= w_vl_ext);

    always_comb begin
        state_d   = state_q;
        arith_d   = arith_q;
        opsel_d   = opsel_q;
        outm_d    = outm_q;
        satm_d    = satm_q;
        scalar_d  = scalar_q;
        vl_d      = vl_q;
        base_d    = base_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    arith_d   = arith_op_i;
                    opsel_d   = operand_sel_i;
                    outm_d    = out_mode_i;
                    satm_d    = sat_mode_i;
                    scalar_d  = scalar_i;
                    vl_d      = vl_i;
                    base_d    = '0;
                    illegal_d = w_op_illegal;
                    state_d   = (w_op_illegal || (vl_i == '0)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pe_ready_i) begin
                    base_d = w_base_next;
                    if (w_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            arith_q   <= '0;
            opsel_q   <= '0;
            outm_q    <= '0;
            satm_q    <= '0;
            scalar_q  <= '0;
            vl_q      <= '0;
            base_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arith_q   <= arith_d;
            opsel_q   <= opsel_d;
            outm_q    <= outm_d;
            satm_q    <= satm_d;
            scalar_q  <= scalar_d;
            vl_q      <= vl_d;
            base_q    <= base_d;
            illegal_q <= illegal_d;
        end
    end

    // Lane enables are qualified by ISSUE so nothing leaks out while idle.
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        assign pe_lane_en_o[i] = w_issuing && ((base_q + BW'(i)) < w_vl_ext);
    end

    assign instr_ready_o    = (state_q == ST_IDLE);
    assign pe_valid_o       = w_issuing;
    assign pe_last_o        = w_issuing && w_last;
    assign pe_arith_op_o    = arith_q;
    assign pe_operand_sel_o = opsel_q;
    assign pe_out_mode_o    = outm_q;
    assign pe_sat_mode_o    = satm_q;
    assign pe_scalar_o      = scalar_q;
    assign pe_elem_base_o   = base_q[VL_W-1:0];
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign illegal_o        = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_accel_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_issue_seq
// Description : Scoreboard bench for accel_issue_seq (NUM_PE=4, VL_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_issue_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [3:0]  arith_op_i;
    logic [1:0]  operand_sel_i;
    logic [1:0]  out_mode_i;
    logic [1:0]  sat_mode_i;
    logic [7:0]  vl_i;
    logic [31:0] scalar_i;
    logic        pe_valid_o;
    logic        pe_ready_i;
    logic [3:0]  pe_arith_op_o;
    logic [1:0]  pe_operand_sel_o;
    logic [1:0]  pe_out_mode_o;
    logic [1:0]  pe_sat_mode_o;
    logic [31:0] pe_scalar_o;
    logic [7:0]  pe_elem_base_o;
    logic [3:0]  pe_lane_en_o;
    logic        pe_last_o;
    logic        busy_o;
    logic        done_o;
    logic        illegal_o;

    accel_issue_seq #(.NUM_PE(4), .VL_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .arith_op_i(arith_op_i), .operand_sel_i(operand_sel_i),
        .out_mode_i(out_mode_i), .sat_mode_i(sat_mode_i),
        .vl_i(vl_i), .scalar_i(scalar_i),
        .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i),
        .pe_arith_op_o(pe_arith_op_o), .pe_operand_sel_o(pe_operand_sel_o),
        .pe_out_mode_o(pe_out_mode_o), .pe_sat_mode_o(pe_sat_mode_o),
        .pe_scalar_o(pe_scalar_o), .pe_elem_base_o(pe_elem_base_o),
        .pe_lane_en_o(pe_lane_en_o), .pe_last_o(pe_last_o),
        .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  base;
        logic [3:0]  lane;
        logic        last;
        logic [3:0]  op;
        logic [1:0]  osel;
        logic [1:0]  om;
        logic [1:0]  sm;
        logic [31:0] scalar;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    done_cnt = 0;
    int    stall_left = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every valid cycle is compared to the scoreboard head; a handshake pops it.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (pe_valid_o) begin
                check("beat_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb[0];
                    check("base",   pe_elem_base_o,   mon_e.base);
                    check("lane",   pe_lane_en_o,     mon_e.lane);
                    check("last",   pe_last_o,        mon_e.last);
                    check("op",     pe_arith_op_o,    mon_e.op);
                    check("osel",   pe_operand_sel_o, mon_e.osel);
                    check("omode",  pe_out_mode_o,    mon_e.om);
                    check("smode",  pe_sat_mode_o,    mon_e.sm);
                    check("scalar", pe_scalar_o,      mon_e.scalar);
                    if (pe_ready_i) void'(sb.pop_front());
                end
            end
            if (done_o) begin
                done_cnt++;
                check("valid_in_done", pe_valid_o, 0);
            end
        end
    end

    initial begin
        pe_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_left > 0 && pe_valid_o) begin
                pe_ready_i = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                pe_ready_i = 1'($urandom_range(0, 1));
            end else begin
                pe_ready_i = 1'b1;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] osel, input logic [1:0] om,
                         input logic [1:0] sm, input logic [7:0] vl, input logic [31:0] sc);
        beat_t e;
        bit    legal;
        int    nb;
        int    t;
        legal = (op <= 4'd9) && (om != 2'd3) && (sm != 2'd3);
        nb    = (legal && vl != 0) ? (int'(vl) + 3) / 4 : 0;
        for (int b = 0; b < nb; b++) begin
            e.base = 8'(b * 4);
            for (int i = 0; i < 4; i++) e.lane[i] = ((b * 4 + i) < int'(vl));
            e.last   = (b == nb - 1);
            e.op     = op;
            e.osel   = osel;
            e.om     = om;
            e.sm     = sm;
            e.scalar = sc;
            sb.push_back(e);
        end
        arith_op_i    = op;
        operand_sel_i = osel;
        out_mode_i    = om;
        sat_mode_i    = sm;
        vl_i          = vl;
        scalar_i      = sc;
        instr_valid_i = 1'b1;
        t = 0;
        while (!instr_ready_o && t < 50) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        check("accept_ready", instr_ready_o, 1);
        @(posedge clk_i);
        #1;
        // Scramble the inputs so any failure to latch shows up on the beats.
        instr_valid_i = 1'b0;
        arith_op_i    = 4'($urandom);
        operand_sel_i = 2'($urandom);
        out_mode_i    = 2'($urandom);
        sat_mode_i    = 2'($urandom);
        vl_i          = 8'($urandom);
        scalar_i      = $urandom;
    endtask

    task automatic finish_op(input int exp_lat, input logic exp_ill);
        int c;
        c = 0;
        do begin
            @(negedge clk_i);
            c++;
        end while (!done_o && c < 300);
        check("done_seen", done_o, 1);
        if (exp_lat >= 0) check("done_latency", c, exp_lat);
        check("illegal", illegal_o, exp_ill);
        #1;
        check("sb_empty", sb.size(), 0);
        @(posedge clk_i);
        #1;
        check("done_pulse_clr", done_o, 0);
        check("illegal_clr", illegal_o, 0);
        check("idle_ready", instr_ready_o, 1);
    endtask

    initial begin
        int d0;
        rst_ni        = 1'b0;
        instr_valid_i = 1'b0;
        arith_op_i    = '0;
        operand_sel_i = '0;
        out_mode_i    = '0;
        sat_mode_i    = '0;
        vl_i          = '0;
        scalar_i      = '0;
        #1;
        check("rst_ready", instr_ready_o, 1);
        check("rst_valid", pe_valid_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_done",  done_o, 0);
        check("rst_ill",   illegal_o, 0);
        check("rst_last",  pe_last_o, 0);
        check("rst_lane",  pe_lane_en_o, 0);
        check("rst_base",  pe_elem_base_o, 0);
        check("rst_op",    pe_arith_op_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        issue(4'd0, 2'd0, 2'd0, 2'd0, 8'd10, 32'h0000_00A5);
        finish_op(4, 1'b0);

        stall_left = 3;
        issue(4'd1, 2'd1, 2'd0, 2'd1, 8'd8, 32'hDEAD_BEEF);
        finish_op(6, 1'b0);

        issue(4'd2, 2'd2, 2'd0, 2'd0, 8'd0, 32'h1234_5678);
        finish_op(1, 1'b0);

        issue(4'd12, 2'd0, 2'd0, 2'd0, 8'd5, 32'h0);
        finish_op(1, 1'b1);

        issue(4'd3, 2'd0, 2'd3, 2'd0, 8'd7, 32'h5);
        finish_op(1, 1'b1);

        issue(4'd9, 2'd3, 2'd2, 2'd2, 8'd255, 32'hCAFE_F00D);
        finish_op(65, 1'b0);

        issue(4'd7, 2'd0, 2'd1, 2'd0, 8'd4, 32'h77);
        finish_op(2, 1'b0);

        rand_ready = 1'b1;
        issue(4'd5, 2'd1, 2'd1, 2'd1, 8'd13, 32'h0BAD_F00D);
        finish_op(-1, 1'b0);
        rand_ready = 1'b0;

        issue(4'd4, 2'd0, 2'd0, 2'd0, 8'd16, 32'h16);
        @(negedge clk_i);
        @(negedge clk_i);
        check("beat2_valid", pe_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", pe_valid_o, 0);
        check("arst_ready", instr_ready_o, 1);
        check("arst_busy",  busy_o, 0);
        check("arst_lane",  pe_lane_en_o, 0);
        check("arst_base",  pe_elem_base_o, 0);
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("arst_no_done", done_cnt, d0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        issue(4'd6, 2'd1, 2'd0, 2'd0, 8'd6, 32'h66);
        finish_op(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accel_issue_seq.md
ACCEL_ISSUE_SEQ -- requirements
Module: accel_issue_seq

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning number of PE lanes per beat (power of two, 2..16).
REQ-002 SHALL have parameter VL_W, default 8, meaning width of the vector-length and element-index fields.
REQ-003 SHALL have clk_i  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have instr_valid_i  input  1  a decoded vector op is offered.
REQ-006 SHALL have instr_ready_o  output  1  the sequencer can accept an op.
REQ-007 SHALL have arith_op_i  input  4  PE arithmetic op code (ADD=0 ... AND=9).
REQ-008 SHALL have operand_sel_i  input  2  operand select (VS1=0, SCALAR=1, IMMEDIATE=2, RIPPLE=3).
REQ-009 SHALL have out_mode_i  input  2  PE output mode (RESULT=0, PASS_MAX=1, PASS_MIN=2).
REQ-010 SHALL have sat_mode_i  input  2  PE saturation mode (NONE=0, SAT=1, SAT_UPPER=2).
REQ-011 SHALL have vl_i  input  VL_W  number of elements to process.
REQ-012 SHALL have scalar_i  input  32  scalar/immediate operand.
REQ-013 SHALL have pe_valid_o  output  1  a PE beat is presented.
REQ-014 SHALL have pe_ready_i  input  1  PE array accepts the beat.
REQ-015 SHALL have pe_arith_op_o, pe_operand_sel_o, pe_out_mode_o, pe_sat_mode_o  output  4/2/2/2  registered copies of the accepted op fields.
REQ-016 SHALL have pe_scalar_o  output  32  registered scalar_i.
REQ-017 SHALL have pe_elem_base_o  output  VL_W  index of the element on lane 0 this beat.
REQ-018 SHALL have pe_lane_en_o  output  NUM_PE  per-lane enable, bit i set when pe_elem_base_o+i < vl.
REQ-019 SHALL have pe_last_o  output  1  the current beat is the final beat of the op.
REQ-020 SHALL have busy_o  output  1  state is not IDLE.
REQ-021 SHALL have done_o  output  1  single-cycle pulse when an op completes.
REQ-022 SHALL have illegal_o  output  1  single-cycle pulse when an accepted op has arith_op_i > 9 or out_mode_i = 3 or sat_mode_i = 3.

Function
REQ-023 SHALL implement states IDLE, ISSUE, DONE.
REQ-024 SHALL drive instr_ready_o = 1 only in IDLE; an op is accepted when instr_valid_i && instr_ready_o.
REQ-025 On acceptance SHALL latch all op fields and vl_i, and set element base to 0.
REQ-026 On acceptance of a legal op with vl_i > 0 SHALL go to ISSUE; first pe_valid_o asserts the next cycle.
REQ-027 On acceptance of vl_i = 0 or an illegal op SHALL go directly to DONE issuing no beats; illegal_o pulses in the cycle after acceptance.
REQ-028 In ISSUE SHALL hold pe_valid_o = 1 and all pe_* outputs stable until pe_ready_i = 1.
REQ-029 On each beat handshake SHALL advance element base by NUM_PE; base arithmetic SHALL be VL_W+1 bits wide so vl near 2^VL_W does not wrap.
REQ-030 SHALL assert pe_last_o when base + NUM_PE >= vl; handshake of the last beat moves to DONE.
REQ-031 Total beats per op SHALL equal ceil(vl/NUM_PE); final-beat lane enables SHALL cover only the remaining vl mod NUM_PE lanes (all lanes if zero remainder).
REQ-032 DONE SHALL last exactly one cycle with done_o = 1, then return to IDLE; back-to-back ops thus see one IDLE cycle between ops.
REQ-033 pe_valid_o SHALL be 0 in IDLE and DONE; instr_valid_i is ignored outside IDLE.
REQ-034 pe_ready_i asserted while pe_valid_o = 0 SHALL have no effect.

Reset
REQ-035 Asserting rst_ni low SHALL immediately force IDLE, abandoning any op in flight with no done_o pulse.
REQ-036 In reset all outputs SHALL be 0 except instr_ready_o = 1; latched fields, base and vl SHALL reset to 0.

Verification
REQ-037 vl=10, NUM_PE=4, pe_ready_i=1, ADD -> 3 beats, bases 0,4,8, lane_en 1111,1111,0011, pe_last on beat 3, done_o one cycle later.
REQ-038 vl=8, pe_ready_i low 3 cycles on beat 1 -> beat 1 fields held unchanged 4 cycles, 2 beats total, lane_en 1111 both.
REQ-039 vl=0 -> no pe_valid_o, done_o pulse cycle after acceptance, illegal_o = 0.
REQ-040 arith_op_i=12, vl=5 -> no beats, illegal_o and done_o pulse together cycle after acceptance.
REQ-041 vl=255, VL_W=8 -> 64 beats, last base 252, lane_en 0111, no wrap of base.
REQ-042 rst_ni low during beat 2 of vl=16 -> pe_valid_o 0 immediately, instr_ready_o 1, no done_o; new op after reset runs from base 0.
